note_buffer_writer: RTL and testbench
=====================================

NOTE_BUFFER_WRITER -- requirements
Module: note_buffer_writer

Interface
REQ-001 SHALL have parameter AW, default 5: bank address width; bank depth is 2^AW entries (32).
REQ-002 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-003 SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port frame_tick, input, 1: one-cycle pulse at vblank start; the only bank-swap point.
REQ-005 SHALL have port in_valid, input, 1: upstream note-y entry valid.
REQ-006 SHALL have port in_y, input, 8: note y coordinate.
REQ-007 SHALL have port in_last, input, 1: marks the final entry of the current frame list; qualified by in_valid.
REQ-008 SHALL have port in_ready, output, 1: writer accepts an entry this cycle.
REQ-009 SHALL have port wr_en, output, 1: RAM write strobe to the back bank.
REQ-010 SHALL have port wr_bank, output, 1: bank index being written (back bank).
REQ-011 SHALL have port wr_addr, output, AW: RAM write address.
REQ-012 SHALL have port wr_data, output, 8: RAM write data.
REQ-013 SHALL have port rd_bank, output, 1: bank the display reader scans (front bank); always the inverse of wr_bank.
REQ-014 SHALL have port disp_count, output, AW+1: number of valid entries in the front bank.
REQ-015 SHALL have port overflow, output, 1: sticky; entries were dropped because the bank was full.
REQ-016 SHALL have port overrun, output, 1: sticky; frame_tick arrived before the list completed.

Function
REQ-017 SHALL implement FSM states FILL, WAIT, SWAP.
REQ-018 SHALL assert in_ready only in FILL, combinationally; an entry is accepted when in_valid && in_ready.
REQ-019 SHALL write each accepted entry in the same cycle: wr_en=1, wr_data=in_y, wr_addr=fill_ptr; fill_ptr then increments.
REQ-020 SHALL, when fill_ptr reaches 2^AW, keep in_ready=1 but drive wr_en=0 for further entries, discard them, and set overflow.
REQ-021 SHALL go FILL->WAIT when an accepted entry has in_last=1, independent of the full condition.
REQ-022 SHALL go WAIT->SWAP on frame_tick; in WAIT, in_ready=0.
REQ-023 SHALL, in SWAP (one cycle): toggle wr_bank/rd_bank, load disp_count with the entry count written (saturated at 2^AW), clear fill_ptr, and go to FILL.
REQ-024 SHALL, on frame_tick in FILL without an accepted in_last that cycle: set overrun, perform no swap, clear fill_ptr, and stay in FILL (back bank refilled).
REQ-025 SHALL treat frame_tick coincident with an accepted in_last entry in FILL as completion: write the entry and go directly to SWAP.
REQ-026 SHALL hold rd_bank and disp_count constant except in the SWAP cycle; the front bank is never written.
REQ-027 SHALL clear overflow and overrun only by reset.
REQ-028 SHALL give the reader the new bank on the cycle after SWAP (swap latency: 2 cycles after frame_tick in WAIT).

Reset
REQ-029 SHALL, on resetn=0 at a clk edge, force: state=FILL, fill_ptr=0, wr_bank=1, rd_bank=0, disp_count=0, overflow=0, overrun=0, wr_en=0.
REQ-030 SHALL give reset priority over all other events, including mid-FILL, and discard any partial list.
REQ-031 SHALL drive in_ready=0 and wr_en=0 while resetn=0.

Verification
REQ-032 Reset, then 3 entries (10,20,30; last on 30), then frame_tick -> bank1 addr0..2 = 10,20,30; two cycles later rd_bank=1, disp_count=3.
REQ-033 Push 40 entries, in_last on the 40th -> 32 writes (addr 0..31), overflow=1, disp_count=32 after swap.
REQ-034 frame_tick after 2 of 5 entries -> overrun=1, rd_bank unchanged, next entry written at addr 0 of the same bank.
REQ-035 in_last entry accepted in the same cycle as frame_tick -> entry written, SWAP next cycle, disp_count includes it.
REQ-036 Two full frames -> rd_bank alternates 0->1->0; no write ever targets the bank equal to rd_bank.
REQ-037 resetn low mid-FILL after 4 entries -> all outputs at reset values next cycle; disp_count=0.

Source files
------------

// File: rtl/note_buffer_writer.sv
// Purpose: writes the per-frame note-y list into the back bank of a double-buffered RAM and swaps banks at vblank.
// Latency: entries are written the cycle they are accepted; the reader sees a new bank 2 cycles after frame_tick in WAIT.
// Backpressure: in_ready is high only in FILL; once the list is complete the writer stalls upstream until the swap.
module note_buffer_writer #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          frame_tick,
  input  logic          in_valid,
  input  logic [7:0]    in_y,
  input  logic          in_last,
  output logic          in_ready,
  output logic          wr_en,
  output logic          wr_bank,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          rd_bank,
  output logic [AW:0]   disp_count,
  output logic          overflow,
  output logic          overrun
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    SWAP = 2'd2
  } state_t;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  state_t      state_q, state_d;
  // One bit wider than the bank address so it can hold 2^AW; the top bit
  // being set means the back bank is full.
  logic [AW:0] fill_ptr_q, fill_ptr_d;
  logic        wr_bank_q, wr_bank_d;
  logic [AW:0] disp_count_q, disp_count_d;
  logic        overflow_q, overflow_d;
  logic        overrun_q, overrun_d;
  logic        bank_full;

  assign bank_full = fill_ptr_q[AW];

  // Next-state and handshake logic; reset gates the handshake so nothing is accepted or written while resetn is low.
  always_comb begin
    state_d      = state_q;
    fill_ptr_d   = fill_ptr_q;
    wr_bank_d    = wr_bank_q;
    disp_count_d = disp_count_q;
    overflow_d   = overflow_q;
    overrun_d    = overrun_q;
    in_ready     = 1'b0;
    wr_en        = 1'b0;

    unique case (state_q)
      FILL: begin
        in_ready = resetn;
        if (in_valid && resetn) begin
          // Entries past the end of the bank are still accepted (so the
          // list can complete) but are dropped rather than written.
          if (bank_full) begin
            overflow_d = 1'b1;
          end else begin
            wr_en      = 1'b1;
            fill_ptr_d = fill_ptr_q + PTR_ONE;
          end
        end
        if (in_valid && resetn && in_last) begin
          // A tick landing on the final entry still counts as a completed list.
          state_d = frame_tick ? SWAP : WAIT;
        end else if (frame_tick) begin
          // List not finished by vblank: keep showing the old front bank and
          // start refilling the back bank from the top.
          overrun_d  = 1'b1;
          fill_ptr_d = '0;
        end
      end
      WAIT: begin
        if (frame_tick) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        wr_bank_d    = ~wr_bank_q;
        disp_count_d = fill_ptr_q;
        fill_ptr_d   = '0;
        state_d      = FILL;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State registers with synchronous active-low reset; any partial list is discarded.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= FILL;
      fill_ptr_q   <= '0;
      wr_bank_q    <= 1'b1;
      disp_count_q <= '0;
      overflow_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_ptr_q   <= fill_ptr_d;
      wr_bank_q    <= wr_bank_d;
      disp_count_q <= disp_count_d;
      overflow_q   <= overflow_d;
      overrun_q    <= overrun_d;
    end
  end

  assign wr_bank    = wr_bank_q;
  assign rd_bank    = ~wr_bank_q;
  assign wr_addr    = fill_ptr_q[AW-1:0];
  assign wr_data    = in_y;
  assign disp_count = disp_count_q;
  assign overflow   = overflow_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_note_buffer_writer.sv
module tb_note_buffer_writer;

  localparam int AW = 5;

  logic          clk;
  logic          resetn;
  logic          frame_tick;
  logic          in_valid;
  logic [7:0]    in_y;
  logic          in_last;
  logic          in_ready;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          rd_bank;
  logic [AW:0]   disp_count;
  logic          overflow;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  int nwrites = 0;
  int conflicts = 0;
  int base;
  logic [7:0] mem [2][32];

  note_buffer_writer #(.AW(AW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .in_valid   (in_valid),
    .in_y       (in_y),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_bank    (rd_bank),
    .disp_count (disp_count),
    .overflow   (overflow),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: capture writes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      mem[wr_bank][wr_addr] = wr_data;
      nwrites++;
      if (wr_bank === rd_bank) conflicts++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] y, input logic last, input logic tick);
    in_valid   = 1'b1;
    in_y       = y;
    in_last    = last;
    frame_tick = tick;
    cyc();
    in_valid   = 1'b0;
    in_last    = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  initial begin
    resetn     = 1'b0;
    frame_tick = 1'b0;
    in_valid   = 1'b1;
    in_y       = 8'hAA;
    in_last    = 1'b0;
    cyc();
    cyc();
    // Reset state, with a valid entry offered during reset
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_bank", wr_bank, 1);
    chk("rst_rd_bank", rd_bank, 0);
    chk("rst_disp_count", disp_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_overrun", overrun, 0);
    in_valid = 1'b0;
    resetn   = 1'b1;
    #1;
    chk("fill_in_ready", in_ready, 1);

    // Basic three-entry frame
    push(8'd10, 1'b0, 1'b0);
    push(8'd20, 1'b0, 1'b0);
    push(8'd30, 1'b1, 1'b0);
    chk("wait_in_ready", in_ready, 0);
    chk("f1_nwrites", nwrites, 3);
    tick();
    chk("f1_swap_rd_bank_hold", rd_bank, 0);
    cyc();
    chk("f1_rd_bank", rd_bank, 1);
    chk("f1_wr_bank", wr_bank, 0);
    chk("f1_disp_count", disp_count, 3);
    chk("f1_mem0", mem[1][0], 10);
    chk("f1_mem1", mem[1][1], 20);
    chk("f1_mem2", mem[1][2], 30);

    // Overflow: 40 entries into a 32-deep bank
    base = nwrites;
    for (int i = 0; i < 40; i++) begin
      if (i == 32) begin
        in_valid = 1'b1;
        in_y     = 8'(100 + i);
        in_last  = 1'b0;
        #1;
        chk("ovf_drop_wr_en", wr_en, 0);
        chk("ovf_in_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;
      end else begin
        push(8'(100 + i), (i == 39), 1'b0);
      end
    end
    chk("ovf_nwrites", nwrites - base, 32);
    chk("ovf_flag", overflow, 1);
    chk("ovf_wait_in_ready", in_ready, 0);
    tick();
    cyc();
    chk("ovf_rd_bank", rd_bank, 0);
    chk("ovf_disp_count", disp_count, 32);
    chk("ovf_mem_first", mem[0][0], 100);
    chk("ovf_mem_last", mem[0][31], 131);

    // Overrun: tick after 2 of 5 entries
    push(8'd50, 1'b0, 1'b0);
    push(8'd51, 1'b0, 1'b0);
    chk("ovr_before", overrun, 0);
    tick();
    chk("ovr_flag", overrun, 1);
    chk("ovr_rd_bank", rd_bank, 0);
    chk("ovr_disp_count", disp_count, 32);
    in_valid = 1'b1;
    in_y     = 8'd52;
    #1;
    chk("ovr_restart_addr", wr_addr, 0);
    chk("ovr_restart_bank", wr_bank, 1);
    chk("ovr_restart_wr_en", wr_en, 1);
    cyc();
    in_valid = 1'b0;
    push(8'd53, 1'b0, 1'b0);
    push(8'd54, 1'b1, 1'b0);
    tick();
    cyc();
    chk("ovr_swap_rd_bank", rd_bank, 1);
    chk("ovr_swap_disp_count", disp_count, 3);
    chk("ovr_mem0", mem[1][0], 52);
    chk("ovr_mem2", mem[1][2], 54);

    // Last entry coincident with frame_tick
    push(8'd60, 1'b0, 1'b0);
    push(8'd61, 1'b1, 1'b1);
    chk("coinc_swap_in_ready", in_ready, 0);
    chk("coinc_swap_rd_bank_hold", rd_bank, 1);
    chk("coinc_overrun_sticky", overrun, 1);
    cyc();
    chk("coinc_rd_bank", rd_bank, 0);
    chk("coinc_disp_count", disp_count, 2);
    chk("coinc_mem1", mem[0][1], 61);
    chk("coinc_overflow_sticky", overflow, 1);
    chk("no_front_bank_writes", conflicts, 0);

    // Reset mid-FILL after 4 entries
    push(8'd70, 1'b0, 1'b0);
    push(8'd71, 1'b0, 1'b0);
    push(8'd72, 1'b0, 1'b0);
    push(8'd73, 1'b0, 1'b0);
    resetn   = 1'b0;
    in_valid = 1'b1;
    in_y     = 8'd74;
    #1;
    chk("rst2_in_ready_low", in_ready, 0);
    chk("rst2_wr_en_low", wr_en, 0);
    cyc();
    chk("rst2_wr_bank", wr_bank, 1);
    chk("rst2_rd_bank", rd_bank, 0);
    chk("rst2_disp_count", disp_count, 0);
    chk("rst2_overflow", overflow, 0);
    chk("rst2_overrun", overrun, 0);
    resetn = 1'b1;
    in_y   = 8'd80;
    #1;
    chk("rst2_restart_addr", wr_addr, 0);
    chk("rst2_restart_wr_en", wr_en, 1);
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("rst2_mem0", mem[1][0], 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
